// File: rtl/sh_ibus_pkg.sv
// Shared IBUS slave definitions: access FSM states, byte-lane numbering and
// helpers that decode the packed debug-tap address parameter.
package sh_ibus_pkg;

   // Read-access sequencing states of a wait-stated IBUS slave
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } ibus_state_t;

   // Byte-enable lane numbering: lane HI carries bits 31:24 (byte offset 0),
   // lane LO carries bits 7:0 (byte offset 3).
   localparam int IBUS_LANE_HI = 3;
   localparam int IBUS_LANE_LO = 0;

   // Packed tap address layout: 12 bits per tap, at most 16 taps
   localparam int TAP_AW   = 12;
   localparam int TAP_MAX  = 16;
   localparam int TAP_BITS = TAP_AW * TAP_MAX;

   // Extract the 12-bit byte address of tap idx from the packed tap vector
   function automatic logic [11:0] tap_addr_f(input logic [TAP_BITS-1:0] taps,
                                              input int idx);
      return taps[idx*TAP_AW +: TAP_AW];
   endfunction

   // Map a big-endian byte offset within a word to its byte-enable lane
   function automatic logic [1:0] tap_lane_f(input logic [1:0] byte_off);
      return 2'(IBUS_LANE_HI - IBUS_LANE_LO) - byte_off;
   endfunction

   // Select the byte carried on a given byte-enable lane
   function automatic logic [7:0] lane_byte_f(input logic [31:0] data,
                                              input logic [1:0]  lane);
      return data[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/sh_be_ram.sv
// Byte-enabled single-clock RAM, 2**AW x 32 bit, built as four independent
// 8-bit lane arrays so partial writes never need a read-modify-write.
// Separate write and read addresses; read data is registered.
module sh_be_ram
   import sh_ibus_pkg::*;
#(
   parameter int AW = 10
)(
   input  logic          clk,
   input  logic          ce,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   for (genvar k = IBUS_LANE_LO; k <= IBUS_LANE_HI; k++) begin : g_lane
      logic [7:0] mem_r [0:(2**AW)-1];
      logic [7:0] rd_r;

      // Lane write on its byte enable; registered read (old data on collision)
      always_ff @(posedge clk) begin
         if (ce) begin
            if (be[k]) begin
               mem_r[waddr] <= wdata[8*k +: 8];
            end
            rd_r <= mem_r[raddr];
         end
      end

      assign rdata[8*k +: 8] = rd_r;
   end

endmodule

// File: rtl/sh_onchip_ram_ws.sv
// On-chip RAM slave on the SH internal bus. Parametrised depth and base
// region, programmable read wait states signalled through IBUS_BUSY,
// byte-lane writes and a set of debug byte-capture taps.
module sh_onchip_ram_ws
   import sh_ibus_pkg::*;
#(
   parameter int                  AW       = 10,
   parameter logic [3:0]          BASE     = 4'hF,
   parameter int                  RD_WS    = 0,
   parameter int                  NTAPS    = 6,
   parameter logic [12*NTAPS-1:0] TAP_ADDR = {NTAPS{12'h000}}
)(
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 CE_R,
   input  logic                 CE_F,
   input  logic [27:0]          IBUS_A,
   input  logic [31:0]          IBUS_DI,
   output logic [31:0]          IBUS_DO,
   input  logic [3:0]           IBUS_BA,
   input  logic                 IBUS_WE,
   input  logic                 IBUS_REQ,
   output logic                 IBUS_BUSY,
   output logic                 IBUS_ACT,
   output logic [8*NTAPS-1:0]   DBG_TAP_Q,
   output logic [NTAPS-1:0]     DBG_TAP_HIT
);

   localparam logic [2:0]          RD_WS_C      = 3'(RD_WS);
   localparam logic [TAP_BITS-1:0] TAP_ADDR_EXT = TAP_BITS'(TAP_ADDR);

   ibus_state_t state_r;
   ibus_state_t state_nxt_s;
   ibus_state_t first_state_s;
   logic [2:0]  cnt_r;
   logic [2:0]  cnt_nxt_s;
   logic [27:0] addr_r;
   logic        busy_s;
   logic        act_s;
   logic        wr_acc_s;
   logic        rd_req_s;
   logic        start_s;
   logic [3:0]  ram_be_s;
   logic        unused_s;

   // CE_F and the address bits outside the decoded fields are not needed here
   assign unused_s = ^{CE_F, IBUS_A};

   assign act_s    = (IBUS_A[27:24] == BASE);
   assign wr_acc_s = IBUS_REQ & act_s & IBUS_WE & CE_R;
   assign rd_req_s = IBUS_REQ & act_s & ~IBUS_WE;
   // With no wait states the RAM simply follows the address and never stalls
   assign start_s  = rd_req_s & (RD_WS_C != 3'd0);
   assign ram_be_s = IBUS_BA & {4{wr_acc_s}};

   // A single wait state skips WAIT and completes on the next CE_R cycle
   assign first_state_s = (RD_WS_C == 3'd1) ? DONE : WAIT;

   sh_be_ram #(
      .AW (AW)
   ) u_ram (
      .clk   (CLK),
      .ce    (CE_R),
      .waddr (IBUS_A[AW+1:2]),
      .be    (ram_be_s),
      .wdata (IBUS_DI),
      .raddr (IBUS_A[AW+1:2]),
      .rdata (IBUS_DO)
   );

   // Read-access FSM: next state, wait counter and BUSY handshake
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      busy_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               busy_s      = 1'b1;
               cnt_nxt_s   = RD_WS_C - 3'd1;
               state_nxt_s = first_state_s;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            busy_s = 1'b1;
            if (!IBUS_REQ) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 3'd0;
            end else if (cnt_r <= 3'd1) begin
               state_nxt_s = DONE;
               cnt_nxt_s   = 3'd0;
            end else begin
               cnt_nxt_s   = cnt_r - 3'd1;
            end
         end
         DONE: begin
            // Only a new address starts a back-to-back read; a held request
            // for the same word is the one just completed.
            if (start_s && (IBUS_A != addr_r)) begin
               busy_s      = 1'b1;
               cnt_nxt_s   = RD_WS_C - 3'd1;
               state_nxt_s = first_state_s;
            end else begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 3'd0;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 3'd0;
         end
      endcase
   end

   // BUSY is released while reset is asserted so a stalled master is freed
   assign IBUS_BUSY = busy_s & RST_N;
   assign IBUS_ACT  = act_s;

   // FSM state, wait counter and in-flight read address advance on CE_R
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= IDLE;
         cnt_r   <= 3'd0;
         addr_r  <= 28'd0;
      end else if (CE_R) begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (busy_s) begin
            addr_r <= IBUS_A;
         end
      end
   end

   for (genvar i = 0; i < NTAPS; i++) begin : g_tap
      localparam logic [11:0] TA   = tap_addr_f(TAP_ADDR_EXT, i);
      localparam logic [1:0]  LANE = tap_lane_f(TA[1:0]);

      logic       match_s;
      logic [7:0] q_r;
      logic       hit_r;

      assign match_s = wr_acc_s & (IBUS_A[11:2] == TA[11:2]) & IBUS_BA[LANE];

      // Capture the tapped byte of an accepted write; hit lasts one CE_R cycle
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            q_r   <= 8'd0;
            hit_r <= 1'b0;
         end else if (CE_R) begin
            hit_r <= match_s;
            if (match_s) begin
               q_r <= lane_byte_f(IBUS_DI, LANE);
            end
         end
      end

      assign DBG_TAP_Q[8*i +: 8] = q_r;
      assign DBG_TAP_HIT[i]      = hit_r;
   end

endmodule
